// File: rtl/max_sort_ctrl.sv
// ============================================================================
// max_sort_ctrl
//
// Sequencer that wraps the bit-sliced max-select core into a full descending
// sorter. One vector of M words is captured, then M rounds run: each round
// presents the still-unsorted ("live") words to the core and waits out the
// core pipeline. It then takes the lowest-index maximal word from the returned
// mask, streams that word out and retires its slot.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready upstream vector handshake, s_data = M words of N bits
//   core_chi        words presented to the core (dead slots forced to 0)
//   core_enable     core enable, high while the core is evaluating
//   core_h_matrix   core mask: bit q set when word q equals the maximum
//   m_valid/m_ready sorted-word handshake; m_data, m_index (original slot),
//                   m_last (M-th word of the vector)
//   busy            high in every state except IDLE
//   err             sticky: a mask arrived with no live bit set
// ============================================================================

package sort_pkg;
    localparam int M = 8;
    localparam int N = 8;
endpackage

module max_sort_ctrl #(
    parameter int M        = sort_pkg::M,
    parameter int N        = sort_pkg::N,
    parameter int CORE_LAT = N - 1,
    parameter int IW       = (M > 1) ? $clog2(M) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [M-1:0][N-1:0]   s_data,
    output logic [M-1:0][N-1:0]   core_chi,
    output logic                  core_enable,
    input  logic [M-1:0]          core_h_matrix,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [N-1:0]          m_data,
    output logic [IW-1:0]         m_index,
    output logic                  m_last,
    output logic                  busy,
    output logic                  err
);

    localparam int RW       = $clog2(M + 1);
    localparam int WW       = ($clog2(CORE_LAT + 1) < 1) ? 1 : $clog2(CORE_LAT + 1);
    localparam int WAIT_END = (CORE_LAT > 0) ? CORE_LAT - 1 : 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_PICK  = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    logic [2:0]          state;
    logic [M-1:0][N-1:0] data_q;
    logic [M-1:0]        live_q;
    logic [RW-1:0]       round_q;
    logic [WW-1:0]       wait_q;
    logic [N-1:0]        m_data_q;
    logic [IW-1:0]       m_index_q;
    logic                m_last_q;
    logic                err_q;

    // ------------------------------------------------------------------------
    // Word selection. Only live slots may win; if the core reports no live
    // maximum the lowest live slot is taken so the vector still drains.
    // ------------------------------------------------------------------------
    logic [M-1:0]  cand;
    logic [M-1:0]  pick_src;
    logic [IW-1:0] sel_idx;
    logic [N-1:0]  sel_data;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cand     = core_h_matrix & live_q;
        pick_src = (cand != '0) ? cand : live_q;
        sel_idx  = '0;
        sel_data = '0;
        // Descending scan so the lowest set index is the last one written.
        for (int q = M - 1; q >= 0; q--) begin
            if (pick_src[q]) begin
                sel_idx  = IW'(q);
                sel_data = data_q[q];
            end
        end
    end

    always_comb begin
        for (int q = 0; q < M; q++) begin
            core_chi[q] = live_q[q] ? data_q[q] : '0;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    // NOTE: the data array is reset along with the control state, so core_chi
    // and m_data come out of reset as zeros rather than stale content.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            live_q    <= '0;
            round_q   <= '0;
            wait_q    <= '0;
            m_data_q  <= '0;
            m_index_q <= '0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        data_q  <= s_data;
                        live_q  <= '1;
                        round_q <= '0;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_q <= '0;
                    state  <= (CORE_LAT == 0) ? ST_PICK : ST_WAIT;
                end
                ST_WAIT: begin
                    wait_q <= wait_q + WW'(1);
                    // Counter runs 0..CORE_LAT-1: CORE_LAT cycles after ISSUE.
                    if (wait_q == WW'(WAIT_END)) begin
                        state <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    m_data_q  <= sel_data;
                    m_index_q <= sel_idx;
                    m_last_q  <= (round_q == RW'(M - 1));
                    if (cand == '0) begin
                        err_q <= 1'b1;
                    end
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (m_ready) begin
                        live_q[m_index_q] <= 1'b0;
                        round_q           <= round_q + RW'(1);
                        state             <= m_last_q ? ST_IDLE : ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready     = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign core_enable = (state == ST_ISSUE) || (state == ST_WAIT);
    assign m_valid     = (state == ST_OUT);
    assign m_data      = m_data_q;
    assign m_index     = m_index_q;
    assign m_last      = m_last_q;
    assign err         = err_q;

endmodule

// File: tb/tb_max_sort_ctrl.sv
// ============================================================================
// tb_max_sort_ctrl
//
// Directed bench for max_sort_ctrl. A behavioural max-select core with a
// CORE_LAT-deep pipeline feeds core_h_matrix. Each stimulus task pushes the
// hand-computed sorted sequence into a scoreboard queue. A monitor compares
// every presented word (including stalled cycles) against the queue head.
// ============================================================================
module tb_max_sort_ctrl;
    localparam int M  = 8;
    localparam int N  = 8;
    localparam int L  = N - 1;
    localparam int IW = 3;

    typedef int vec_t[M];
    typedef struct {
        int d;
        int i;
        bit l;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [M-1:0][N-1:0] s_data = '0;
    logic [M-1:0][N-1:0] core_chi;
    logic                core_enable;
    logic [M-1:0]        core_h_matrix;
    logic                m_valid;
    logic                m_ready = 1'b1;
    logic [N-1:0]        m_data;
    logic [IW-1:0]       m_index;
    logic                m_last;
    logic                busy;
    logic                err;

    max_sort_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_chi(core_chi), .core_enable(core_enable), .core_h_matrix(core_h_matrix),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_index(m_index), .m_last(m_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural core ----------------
    logic [M-1:0] stage [L];
    logic         force_zero = 1'b0;

    function automatic logic [M-1:0] max_mask(input logic [M-1:0][N-1:0] w);
        logic [N-1:0] mx;
        logic [M-1:0] r;
        mx = '0;
        for (int q = 0; q < M; q++) if (w[q] > mx) mx = w[q];
        r = '0;
        for (int q = 0; q < M; q++) r[q] = (w[q] == mx);
        return r;
    endfunction

    always @(posedge clk) begin
        stage[0] <= core_enable ? max_mask(core_chi) : '0;
        for (int k = 1; k < L; k++) stage[k] <= stage[k-1];
    end

    assign core_h_matrix = force_zero ? '0 : stage[L-1];

    // ---------------- scoreboard / monitor ----------------
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   n_xfer = 0;
    exp_t exp_q[$];
    int   acc_log[$];
    int   last_log[$];

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) acc_log.push_back(cyc);
            if (m_valid) begin
                check("s_ready_low_while_busy", int'(s_ready), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    check("m_data",  int'(m_data),  exp_q[0].d);
                    check("m_index", int'(m_index), exp_q[0].i);
                    check("m_last",  int'(m_last),  int'(exp_q[0].l));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        n_xfer++;
                        force_zero = 1'b0;
                        if (m_last) last_log.push_back(cyc);
                    end
                end
            end
        end
    end

    // ---------------- backpressure driver ----------------
    bit       bp_mode = 1'b0;
    bit [3:0] bp_pat  = 4'b1001;  // 1,0,0,1 read from bit 0 upward
    int       bp_ph   = 0;

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            m_ready = bp_pat[bp_ph];
            bp_ph   = (bp_ph + 1) % 4;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_exp(input vec_t ev, input vec_t ei);
        for (int k = 0; k < M; k++) begin
            exp_t e;
            e.d = ev[k];
            e.i = ei[k];
            e.l = (k == M - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic load(input vec_t v);
        for (int k = 0; k < M; k++) s_data[k] = N'(v[k]);
    endtask

    // Holds s_valid until the accepting edge; leaves s_valid high afterwards.
    task automatic offer(input vec_t v);
        bit got;
        load(v);
        s_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            @(negedge clk);
            if (s_ready) got = 1'b1;
        end
        if (!got) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, input vec_t ev, input vec_t ei);
        push_exp(ev, ei);
        offer(v);
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- directed vectors ----------------
    vec_t va  = '{7, 3, 9, 0, 255, 1, 128, 64};
    vec_t vad = '{255, 128, 64, 9, 7, 3, 1, 0};
    vec_t vai = '{4, 6, 7, 2, 0, 1, 5, 3};
    vec_t vt  = '{5, 5, 5, 5, 5, 5, 5, 5};
    vec_t vid = '{0, 1, 2, 3, 4, 5, 6, 7};
    vec_t vm  = '{9, 2, 9, 2, 9, 2, 9, 2};
    vec_t vmd = '{9, 9, 9, 9, 2, 2, 2, 2};
    vec_t vmi = '{0, 2, 4, 6, 1, 3, 5, 7};
    vec_t vb  = '{10, 20, 30, 40, 50, 60, 70, 80};
    vec_t vbd = '{80, 70, 60, 50, 40, 30, 20, 10};
    vec_t vbi = '{7, 6, 5, 4, 3, 2, 1, 0};
    vec_t v2  = '{0, 0, 1, 1, 200, 3, 3, 0};
    vec_t v2d = '{200, 3, 3, 1, 1, 0, 0, 0};
    vec_t v2i = '{4, 5, 6, 2, 3, 0, 1, 7};
    vec_t vr  = '{3, 1, 4, 1, 5, 9, 2, 6};
    vec_t vrd = '{9, 6, 5, 4, 3, 2, 1, 1};
    vec_t vri = '{5, 7, 4, 2, 0, 6, 1, 3};
    vec_t ved = '{7, 255, 128, 64, 9, 3, 1, 0};
    vec_t vei = '{0, 4, 6, 7, 2, 1, 5, 3};

    initial begin
        // Reset state
        #12;
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_core_enable", int'(core_enable), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_index", int'(m_index), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_core_chi", int'(core_chi == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic sort and accept-to-last latency with m_ready high
        acc_log.delete();
        last_log.delete();
        send(va, vad, vai);
        wait_done();
        if (acc_log.size() > 0 && last_log.size() > 0)
            check("latency_accept_to_last", last_log[0] - acc_log[0], M * (L + 3));
        else
            check("latency_logged", 0, 1);

        // Ties
        send(vt, vt, vid);
        wait_done();
        send(vm, vmd, vmi);
        wait_done();

        // Backpressure
        bp_mode = 1'b1;
        send(vb, vbd, vbi);
        wait_done();
        bp_mode = 1'b0;
        m_ready = 1'b1;

        // Back-to-back vectors with s_valid held high
        acc_log.delete();
        last_log.delete();
        push_exp(vad, vai);
        push_exp(v2d, v2i);
        offer(va);
        offer(v2);
        s_valid = 1'b0;
        wait_done();
        if (acc_log.size() > 1 && last_log.size() > 0)
            check("b2b_accept_after_last", acc_log[1] - last_log[0], 1);
        else
            check("b2b_logged", 0, 1);

        // Reset while the 4th word is presented
        begin
            int  b;
            bit  hit;
            b = n_xfer;
            send(va, vad, vai);
            hit = 1'b0;
            for (int c = 0; c < 500 && !hit; c++) begin
                @(posedge clk);
                #2;
                if (n_xfer >= b + 3 && m_valid) hit = 1'b1;
            end
            if (!hit) check("reset_point_timeout", 0, 1);
            rst_n = 1'b0;
            #1;
            check("midrst_m_valid", int'(m_valid), 0);
            check("midrst_s_ready", int'(s_ready), 1);
            check("midrst_busy", int'(busy), 0);
            check("midrst_m_data", int'(m_data), 0);
            check("midrst_core_enable", int'(core_enable), 0);
            exp_q.delete();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        send(vr, vrd, vri);
        wait_done();
        check("err_before_fault", int'(err), 0);

        // Empty mask in round 0
        force_zero = 1'b1;
        send(va, ved, vei);
        wait_done();
        check("err_set", int'(err), 1);
        send(vt, vt, vid);
        wait_done();
        check("err_sticky", int'(err), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, required completion");
        $fatal(1);
    end

endmodule
